// File: rtl/uart_pkg.sv
// Definitions shared by the lab UART receiver and transmitter: FSM states,
// bit-timing arithmetic and the parity convention.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        BREAK  = 3'd5
    } state_t;

    // 0 selects even parity: the parity bit makes the total count of ones even.
    localparam logic PARITY_ODD = 1'b0;

    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned cpb);
        return $clog2(cpb) + 1;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial line input and parallel word output of the UART receiver.
interface uart_rx_if #(
    parameter int unsigned WL = 8
);
    logic          uart_rx;
    logic [WL-1:0] rx_word;
    logic          rx_vld;
    logic          parity_err;
    logic          frame_err;
    logic          busy;

    // master: the receiver itself; slave: the line driver / word consumer.
    modport master (
        input  uart_rx,
        output rx_word, rx_vld, parity_err, frame_err, busy
    );

    modport slave (
        output uart_rx,
        input  rx_word, rx_vld, parity_err, frame_err, busy
    );
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);
    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q <= RESET_VAL;
            s2_q <= RESET_VAL;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;
endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, WL data bits LSB first, parity, one stop bit.
// Strobes each word with rx_vld together with its parity/frame error flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned WL        = 8,
    parameter int unsigned BAUD_RATE = 9600,
    parameter int unsigned CLK_FREQ  = 100000000
) (
    input  logic     CLK,
    input  logic     RST,
    uart_rx_if.master bus
);
    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int unsigned CW           = cnt_width(CLKS_PER_BIT);

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] WORD_LAST = CW'(WL - 1);

    logic          rx_s2;

    state_t        state_q,   state_d;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic [WL-1:0] shift_q,   shift_d;
    logic          par_bad_q, par_bad_d;
    logic [WL-1:0] rx_word_q, rx_word_d;
    logic          rx_vld_q,  rx_vld_d;
    logic          perr_q,    perr_d;
    logic          ferr_q,    ferr_d;
    logic          bit_end;

    // Line idles high, so the synchronizer resets high to avoid a false start.
    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk_i (CLK),
        .rst_i (RST),
        .d_i   (bus.uart_rx),
        .q_o   (rx_s2)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_bad_q <= 1'b0;
            rx_word_q <= '0;
            rx_vld_q  <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_bad_q <= par_bad_d;
            rx_word_q <= rx_word_d;
            rx_vld_q  <= rx_vld_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
        end
    end

    assign bit_end = (clk_cnt_q == BIT_LAST);

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_bad_d = par_bad_q;
        rx_word_d = rx_word_q;
        rx_vld_d  = 1'b0;
        perr_d    = perr_q;
        ferr_d    = ferr_q;

        unique case (state_q)
            IDLE: begin
                if (!rx_s2) begin
                    clk_cnt_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = rx_s2 ? IDLE : DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s2, shift_q[WL-1:1]};
                    bit_cnt_d = bit_cnt_q + CW'(1);
                    if (bit_cnt_q == WORD_LAST) begin
                        state_d = PARITY;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            PARITY: begin
                if (bit_end) begin
                    clk_cnt_d = '0;
                    par_bad_d = rx_s2 ^ (^shift_q) ^ PARITY_ODD;
                    state_d   = STOP;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            STOP: begin
                // Leave at mid stop bit so an immediately following start edge is caught.
                if (bit_end) begin
                    clk_cnt_d = '0;
                    rx_word_d = shift_q;
                    perr_d    = par_bad_q;
                    ferr_d    = ~rx_s2;
                    rx_vld_d  = 1'b1;
                    state_d   = rx_s2 ? IDLE : BREAK;
                end else begin
                    clk_cnt_d = clk_cnt_q + CW'(1);
                end
            end
            BREAK: begin
                if (rx_s2) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.rx_word    = rx_word_q;
    assign bus.rx_vld     = rx_vld_q;
    assign bus.parity_err = perr_q;
    assign bus.frame_err  = ferr_q;
    assign bus.busy       = (state_q == START) || (state_q == DATA) ||
                            (state_q == PARITY) || (state_q == STOP);

    a_vld_single : assert property (@(posedge CLK) disable iff (RST)
        rx_vld_q |=> !rx_vld_q);
endmodule
